spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_responder_if.sv | 10 +
 rtl/spi_flash_responder.sv | 195 +++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_if.sv
// SPI bus between an initiator (master) and the flash responder (slave).
interface spi_flash_responder_if;
    logic sclk;
    logic SS;
    logic MOSI;
    logic MISO;

    modport master (output sclk, output SS, output MOSI, input MISO);
    modport slave  (input sclk, input SS, input MOSI, output MISO);
endinterface

// File: rtl/spi_flash_responder.sv
// Mode-0 SPI flash responder: WREN / PP / READ / RDSR over a small byte memory.
// Optional busy timer after page program: define SPI_FLASH_BUSY_EN.
module spi_flash_responder #(
    parameter int ADDR_BITS   = 4,
    parameter int PROG_CYCLES = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    spi_flash_responder_if.slave spi,
    output logic [7:0]           status
);
    localparam int         MEM_BYTES = 2 ** ADDR_BITS;
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_PP    = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_RDSR  = 8'h05;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DATA_IN, DATA_OUT, STAT_OUT, IGNORE
    } state_t;

    state_t state, state_next;

    logic [1:0] sclk_sync, ss_sync, mosi_sync;
    logic       sclk_prev, ss_prev;
    logic       sclk_rise, sclk_fall, ss_rise, ss_fall, mosi;

    logic [6:0]           rx_sh;
    logic [7:0]           rx_next;
    logic [4:0]           bit_cnt;
    logic                 last_bit;
    logic [ADDR_BITS-1:0] addr, addr_shift, addr_inc;
    logic [7:0]           tx_sh;
    logic [2:0]           tx_cnt;
    logic                 miso_q;
    logic                 wel, wip;
    logic                 wren_ok, pp_frame;
    logic                 mem_we;

    // NOTE: memory has no reset; contents survive reset and power up as 0xFF.
    logic [7:0] mem [MEM_BYTES] = '{default: 8'hFF};

    // SS chain resets low so a frame already in progress at reset release
    // never looks like a fresh SS falling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments.
            sclk_sync <= {sclk_sync[0], spi.sclk};
            ss_sync   <= {ss_sync[0], spi.SS};
            mosi_sync <= {mosi_sync[0], spi.MOSI};
            sclk_prev <= sclk_sync[1];
            ss_prev   <= ss_sync[1];
        end
    end

    assign sclk_rise  = sclk_sync[1] & ~sclk_prev;
    assign sclk_fall  = ~sclk_sync[1] & sclk_prev;
    assign ss_fall    = ss_prev & ~ss_sync[1];
    assign ss_rise    = ~ss_prev & ss_sync[1];
    assign mosi       = mosi_sync[1];

    assign rx_next    = {rx_sh, mosi};
    assign last_bit   = (bit_cnt == 5'd7);
    assign addr_shift = ADDR_BITS'({addr, mosi});
    assign addr_inc   = addr + ADDR_BITS'(1);
    assign status     = {6'b0, wel, wip};
    assign spi.MISO   = miso_q;

    assign mem_we = sclk_rise && !ss_rise && !ss_fall && state == DATA_IN && last_bit && wel;

    always_ff @(posedge clock) begin
        if (mem_we) mem[addr] <= rx_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch forms.
        state_next = state;
        if (ss_rise) begin
            state_next = IDLE;
        end else if (ss_fall) begin
            state_next = CMD;
        end else if (sclk_rise) begin
            case (state)
                CMD: if (last_bit) begin
                    if (rx_next == CMD_RDSR)
                        state_next = STAT_OUT;
                    else if ((rx_next == CMD_PP || rx_next == CMD_READ) && !wip)
                        state_next = ADDR;
                    else
                        state_next = IGNORE;
                end
                ADDR: if (bit_cnt == 5'd23) state_next = pp_frame ? DATA_IN : DATA_OUT;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_sh    <= '0;
            bit_cnt  <= '0;
            addr     <= '0;
            tx_sh    <= '0;
            tx_cnt   <= '0;
            miso_q   <= 1'b1;
            wel      <= 1'b0;
            wren_ok  <= 1'b0;
            pp_frame <= 1'b0;
        end else begin
            if (state != DATA_OUT && state != STAT_OUT) miso_q <= 1'b1;

            if (ss_fall) begin
                bit_cnt  <= '0;
                wren_ok  <= 1'b0;
                pp_frame <= 1'b0;
            end else if (ss_rise) begin
                if (wren_ok)  wel <= 1'b1;
                if (pp_frame) wel <= 1'b0;
            end else if (sclk_rise && state != IDLE) begin
                rx_sh <= rx_next[6:0];
                if ((state == ADDR) ? (bit_cnt == 5'd23) : last_bit) bit_cnt <= '0;
                else                                                  bit_cnt <= bit_cnt + 5'd1;
                case (state)
                    CMD: if (last_bit) begin
                        wren_ok  <= (rx_next == CMD_WREN) && !wip;
                        pp_frame <= (rx_next == CMD_PP) && !wip;
                        tx_sh    <= status;
                        tx_cnt   <= '0;
                    end
                    ADDR: begin
                        addr <= addr_shift;
                        if (bit_cnt == 5'd23) begin
                            tx_sh  <= mem[addr_shift];
                            tx_cnt <= '0;
                        end
                    end
                    DATA_IN: if (last_bit) addr <= addr_inc;
                    // Any bit past the WREN opcode disqualifies it.
                    IGNORE: wren_ok <= 1'b0;
                    default: ;
                endcase
            end else if (sclk_fall && (state == DATA_OUT || state == STAT_OUT)) begin
                miso_q <= tx_sh[7];
                if (tx_cnt == 3'd7) begin
                    tx_cnt <= '0;
                    if (state == DATA_OUT) begin
                        addr  <= addr_inc;
                        tx_sh <= mem[addr_inc];
                    end else begin
                        tx_sh <= status;
                    end
                end else begin
                    tx_sh  <= {tx_sh[6:0], 1'b0};
                    tx_cnt <= tx_cnt + 3'd1;
                end
            end
        end
    end

`ifdef SPI_FLASH_BUSY_EN
    localparam int BUSY_W = $clog2(PROG_CYCLES + 1);

    logic [BUSY_W-1:0] busy_cnt;
    logic              wrote;

    // Only a PP frame that actually committed a byte starts the program timer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
            wrote    <= 1'b0;
        end else begin
            if (ss_fall)     wrote <= 1'b0;
            else if (mem_we) wrote <= 1'b1;

            if (ss_rise && pp_frame && wrote) busy_cnt <= BUSY_W'(PROG_CYCLES);
            else if (busy_cnt != '0)          busy_cnt <= busy_cnt - BUSY_W'(1);
        end
    end

    assign wip = (busy_cnt != '0);
`else
    assign wip = 1'b0;
`endif
endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench for spi_flash_responder against a byte-array flash model.
module tb_spi_flash_responder;
    localparam int ADDR_BITS = 4;
    localparam int MEM_BYTES = 16;
    localparam int PROG      = 1500;
    localparam int HALF      = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] status;

    always #5 clock = ~clock;

    spi_flash_responder_if spi ();

    spi_flash_responder #(
        .ADDR_BITS  (ADDR_BITS),
        .PROG_CYCLES(PROG)
    ) dut (
        .clock (clock),
        .reset (reset),
        .spi   (spi),
        .status(status)
    );

    int         checks_total  = 0;
    int         checks_passed = 0;
    logic [7:0] model_mem [MEM_BYTES];
    logic       model_wel;
    logic       model_wip;
    logic [7:0] tx_buf [16];
    logic [7:0] rx_buf [16];

    task automatic idle_clocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic xfer_byte(input logic [7:0] t, output logic [7:0] r);
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            spi.MOSI = t[i];
            idle_clocks(HALF);
            r[i] = spi.MISO;
            spi.sclk = 1'b1;
            idle_clocks(HALF);
            spi.sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int nbytes, input int extra_bits);
        logic [7:0] r;
        spi.SS = 1'b0;
        idle_clocks(4);
        for (int b = 0; b < nbytes; b++) begin
            xfer_byte(tx_buf[b], r);
            rx_buf[b] = r;
        end
        for (int i = 0; i < extra_bits; i++) begin
            spi.MOSI = tx_buf[nbytes][7-i];
            idle_clocks(HALF);
            spi.sclk = 1'b1;
            idle_clocks(HALF);
            spi.sclk = 1'b0;
        end
        idle_clocks(HALF);
        spi.SS = 1'b1;
        idle_clocks(8);
    endtask

    function automatic logic [7:0] model_status();
        return {6'b0, model_wel, model_wip};
    endfunction

    task automatic do_wren();
        tx_buf[0] = 8'h06;
        run_frame(1, 0);
        model_wel = 1'b1;
    endtask

    // Data bytes are pre-loaded by the caller into tx_buf[4..].
    task automatic do_pp(input logic [23:0] a, input int n, input int extra_bits, input bit wait_busy);
        bit wrote;
        tx_buf[0] = 8'h02;
        tx_buf[1] = a[23:16];
        tx_buf[2] = a[15:8];
        tx_buf[3] = a[7:0];
        run_frame(4 + n, extra_bits);
        wrote = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (model_wel) begin
                model_mem[(int'(a) + k) % MEM_BYTES] = tx_buf[4+k];
                wrote = 1'b1;
            end
        end
        model_wel = 1'b0;
`ifdef SPI_FLASH_BUSY_EN
        if (wrote) begin
            model_wip = 1'b1;
            if (wait_busy) begin
                idle_clocks(PROG + 20);
                model_wip = 1'b0;
            end
        end
`else
        if (wrote && wait_busy) idle_clocks(2);
`endif
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        tx_buf[0] = 8'h03;
        tx_buf[1] = a[23:16];
        tx_buf[2] = a[15:8];
        tx_buf[3] = a[7:0];
        for (int k = 0; k < n; k++) tx_buf[4+k] = 8'($urandom);
        run_frame(4 + n, 0);
    endtask

    task automatic do_rdsr(input int n);
        tx_buf[0] = 8'h05;
        for (int k = 1; k <= n; k++) tx_buf[k] = 8'($urandom);
        run_frame(1 + n, 0);
    endtask

    task automatic test_reset();
        spi.SS = 1'b1; spi.sclk = 1'b0; spi.MOSI = 1'b0;
        reset = 1'b1;
        model_wel = 1'b0;
        model_wip = 1'b0;
        idle_clocks(5);
        checks_total++;
        if (spi.MISO !== 1'b1) $display("FAIL reset_miso: got %b expected 1", spi.MISO);
        else checks_passed++;
        checks_total++;
        if (status !== 8'h00) $display("FAIL reset_status: got %h expected 00", status);
        else checks_passed++;
        reset = 1'b0;
        idle_clocks(10);
        checks_total++;
        if (spi.MISO !== 1'b1 || status !== model_status())
            $display("FAIL post_reset: got miso=%b status=%h expected miso=1 status=%h", spi.MISO, status, model_status());
        else checks_passed++;
    endtask

    task automatic test_wren_rdsr();
        do_wren();
        checks_total++;
        if (status !== model_status()) $display("FAIL wren_status: got %h expected %h", status, model_status());
        else checks_passed++;
        do_rdsr(2);
        checks_total++;
        if (rx_buf[0] !== 8'hFF) $display("FAIL rdsr_cmd_miso: got %h expected ff", rx_buf[0]);
        else checks_passed++;
        for (int k = 1; k <= 2; k++) begin
            checks_total++;
            if (rx_buf[k] !== model_status()) $display("FAIL rdsr_byte%0d: got %h expected %h", k, rx_buf[k], model_status());
            else checks_passed++;
        end
    endtask

    task automatic test_pp_read();
        do_wren();
        tx_buf[4] = 8'hAA;
        do_pp(24'h1FFFF0, 1, 0, 1'b1);
        checks_total++;
        if (status !== model_status()) $display("FAIL pp_clears_wel: got %h expected %h", status, model_status());
        else checks_passed++;
        do_read(24'h1FFFF0, 1);
        checks_total++;
        if ({rx_buf[1], rx_buf[2], rx_buf[3]} !== 24'hFFFFFF)
            $display("FAIL read_addr_miso: got %h%h%h expected ffffff", rx_buf[1], rx_buf[2], rx_buf[3]);
        else checks_passed++;
        checks_total++;
        if (rx_buf[4] !== model_mem[0]) $display("FAIL pp_read_aa: got %h expected %h", rx_buf[4], model_mem[0]);
        else checks_passed++;
    endtask

    task automatic test_pp_no_wren();
        tx_buf[4] = 8'h55;
        do_pp(24'h000003, 1, 0, 1'b1);
        do_read(24'h000003, 1);
        checks_total++;
        if (rx_buf[4] !== model_mem[3]) $display("FAIL pp_no_wren: got %h expected %h", rx_buf[4], model_mem[3]);
        else checks_passed++;
    endtask

    task automatic test_wrap();
        do_wren();
        tx_buf[4] = 8'h11;
        tx_buf[5] = 8'h22;
        do_pp(24'h00000F, 2, 0, 1'b1);
        do_read(24'h00000F, 2);
        checks_total++;
        if (rx_buf[4] !== model_mem[15]) $display("FAIL wrap_byte0: got %h expected %h", rx_buf[4], model_mem[15]);
        else checks_passed++;
        checks_total++;
        if (rx_buf[5] !== model_mem[0]) $display("FAIL wrap_byte1: got %h expected %h", rx_buf[5], model_mem[0]);
        else checks_passed++;
    endtask

    task automatic test_partial_byte();
        logic [23:0] a;
        a = 24'($urandom);
        do_wren();
        tx_buf[4] = ~model_mem[a % MEM_BYTES];
        do_pp(a, 0, 5, 1'b1);
        checks_total++;
        if (status !== model_status()) $display("FAIL partial_wel: got %h expected %h", status, model_status());
        else checks_passed++;
        do_read(a, 1);
        checks_total++;
        if (rx_buf[4] !== model_mem[a % MEM_BYTES])
            $display("FAIL partial_mem: got %h expected %h", rx_buf[4], model_mem[a % MEM_BYTES]);
        else checks_passed++;
    endtask

    task automatic test_ignore();
        tx_buf[0] = 8'h06;
        tx_buf[1] = 8'($urandom);
        run_frame(1, 1);
        checks_total++;
        if (status !== model_status()) $display("FAIL wren_9bits: got %h expected %h", status, model_status());
        else checks_passed++;
        tx_buf[0] = 8'h9F;
        tx_buf[1] = 8'($urandom);
        tx_buf[2] = 8'($urandom);
        run_frame(3, 0);
        checks_total++;
        if (rx_buf[1] !== 8'hFF || rx_buf[2] !== 8'hFF)
            $display("FAIL unknown_cmd_miso: got %h %h expected ff ff", rx_buf[1], rx_buf[2]);
        else checks_passed++;
    endtask

    task automatic test_random();
        logic [23:0] a, ra;
        int          n;
        for (int it = 0; it < 8; it++) begin
            a = 24'($urandom);
            n = $urandom_range(1, 5);
            if ($urandom_range(0, 2) != 0) do_wren();
            for (int k = 0; k < n + 1; k++) tx_buf[4+k] = 8'($urandom);
            do_pp(a, n, $urandom_range(0, 7), 1'b1);
            checks_total++;
            if (status !== model_status()) $display("FAIL rand_status it%0d: got %h expected %h", it, status, model_status());
            else checks_passed++;
            ra = ($urandom_range(0, 1) != 0) ? a : 24'($urandom);
            do_read(ra, 4);
            for (int k = 0; k < 4; k++) begin
                checks_total++;
                if (rx_buf[4+k] !== model_mem[(int'(ra) + k) % MEM_BYTES])
                    $display("FAIL rand_read it%0d byte%0d: got %h expected %h", it, k, rx_buf[4+k],
                             model_mem[(int'(ra) + k) % MEM_BYTES]);
                else checks_passed++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] r;
        do_wren();
        spi.SS = 1'b0;
        idle_clocks(4);
        xfer_byte(8'h03, r);
        xfer_byte(8'h00, r);
        xfer_byte(8'h00, r);
        reset = 1'b1;
        idle_clocks(3);
        reset = 1'b0;
        model_wel = 1'b0;
        model_wip = 1'b0;
        idle_clocks(4);
        for (int k = 0; k < 3; k++) begin
            xfer_byte(8'($urandom), r);
            checks_total++;
            if (r !== 8'hFF) $display("FAIL aborted_frame_miso byte%0d: got %h expected ff", k, r);
            else checks_passed++;
        end
        idle_clocks(HALF);
        spi.SS = 1'b1;
        idle_clocks(8);
        do_rdsr(1);
        checks_total++;
        if (rx_buf[1] !== model_status()) $display("FAIL midreset_rdsr: got %h expected %h", rx_buf[1], model_status());
        else checks_passed++;
        do_read(24'h000007, 2);
        checks_total++;
        if (rx_buf[4] !== model_mem[7] || rx_buf[5] !== model_mem[8])
            $display("FAIL midreset_read: got %h %h expected %h %h", rx_buf[4], rx_buf[5], model_mem[7], model_mem[8]);
        else checks_passed++;
    endtask

`ifdef SPI_FLASH_BUSY_EN
    task automatic test_busy();
        logic [23:0] a;
        a = 24'($urandom);
        do_wren();
        tx_buf[4] = 8'($urandom);
        do_pp(a, 1, 0, 1'b0);
        do_rdsr(1);
        checks_total++;
        if (rx_buf[1] !== model_status()) $display("FAIL busy_rdsr: got %h expected %h", rx_buf[1], model_status());
        else checks_passed++;
        do_read(a, 2);
        checks_total++;
        if (rx_buf[4] !== 8'hFF || rx_buf[5] !== 8'hFF)
            $display("FAIL busy_read_miso: got %h %h expected ff ff", rx_buf[4], rx_buf[5]);
        else checks_passed++;
        idle_clocks(PROG);
        model_wip = 1'b0;
        do_rdsr(1);
        checks_total++;
        if (rx_buf[1] !== model_status()) $display("FAIL after_busy_rdsr: got %h expected %h", rx_buf[1], model_status());
        else checks_passed++;
        do_read(a, 1);
        checks_total++;
        if (rx_buf[4] !== model_mem[a % MEM_BYTES])
            $display("FAIL after_busy_read: got %h expected %h", rx_buf[4], model_mem[a % MEM_BYTES]);
        else checks_passed++;
    endtask
`endif

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'hFF;
        test_reset();
        test_wren_rdsr();
        test_pp_read();
        test_pp_no_wren();
        test_wrap();
        test_partial_byte();
        test_ignore();
        test_random();
        test_reset_midframe();
`ifdef SPI_FLASH_BUSY_EN
        test_busy();
`endif
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
